// File: rtl/alu_pkg.sv
// Opcode encodings and multiply-sequencer types shared by the control unit, the ALU and mul_sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

  // 0x80000000 maps to itself, which is correct once read as unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Execute-stage handshake between the control unit (master) and the multiply sequencer (slave).
interface mul_sequencer_if;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, aluop, a, b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, aluop, a, b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Iterative shift-add datapath: operand conditioning, accumulator, sign fix-up and half select.
module mul_shift_add_dp
  import alu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        finish,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic        neg_r;
  logic        hi_r;
  logic [31:0] result_r;

  logic        signed_op_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        neg_s;
  logic [63:0] partial_s;
  logic [63:0] acc_next_s;
  logic [63:0] prod_s;

  // Only MULH works on magnitudes; MUL and MULHU read both operands as unsigned.
  always_comb begin
    signed_op_s = (op == ALU_MULH);
    if (signed_op_s) begin
      a_mag_s = mag32(a);
      b_mag_s = mag32(b);
      neg_s   = a[31] ^ b[31];
    end else begin
      a_mag_s = a;
      b_mag_s = b;
      neg_s   = 1'b0;
    end
  end

  // Partial product of this iteration, next accumulator and the sign-corrected product.
  always_comb begin
    partial_s = 64'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_r[i]) begin
        partial_s = partial_s + (mcand_r << i);
      end else begin
        partial_s = partial_s;
      end
    end
    acc_next_s = acc_r + partial_s;
    if (neg_r) begin
      prod_s = ~acc_next_s + 64'd1;
    end else begin
      prod_s = acc_next_s;
    end
  end

  // Operand load, per-iteration accumulate, and result capture on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= 64'd0;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      neg_r    <= 1'b0;
      hi_r     <= 1'b0;
      result_r <= 32'd0;
    end else if (load) begin
      acc_r    <= 64'd0;
      mcand_r  <= {32'd0, a_mag_s};
      mplier_r <= b_mag_s;
      neg_r    <= neg_s;
      hi_r     <= (op != ALU_MUL);
    end else if (step) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << BITS_PER_CYCLE;
      mplier_r <= mplier_r >> BITS_PER_CYCLE;
      if (finish) begin
        result_r <= hi_r ? prod_s[63:32] : prod_s[31:0];
      end
    end
  end

  assign result = result_r;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle controller for MUL/MULH/MULHU: owns the FSM, iteration counter and stall/done signalling.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int XLEN           = 32
) (
  input logic            clk,
  input logic            rst,
  mul_sequencer_if.slave bus
);

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER);

  mul_state_t      state_r;
  logic [CW-1:0]   counter_r;
  logic            busy_r;
  logic            done_r;

  logic            is_mul_s;
  logic            accept_s;
  logic            step_s;
  logic            finish_s;
  logic            stall_s;
  logic [31:0]     result_s;

  mul_sequencer_chk #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_chk ();

  // Accept, datapath strobes and stall; stall is combinational so the PC holds in the issue cycle.
  always_comb begin
    is_mul_s = bus.start & is_mul_op(bus.aluop);
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = is_mul_s & ~bus.flush;
        stall_s  = accept_s;
      end
      RUN: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          step_s = 1'b0;
        end else begin
          step_s   = 1'b1;
          finish_s = (counter_r == {CW{1'b0}});
        end
      end
      DONE: begin
        stall_s = 1'b0;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered busy/done; DONE always lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      counter_r <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= RUN;
            counter_r <= CW'(ITER - 1);
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_r   <= IDLE;
            counter_r <= {CW{1'b0}};
            busy_r    <= 1'b0;
          end else if (counter_r == {CW{1'b0}}) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            counter_r <= counter_r - CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          counter_r <= {CW{1'b0}};
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  mul_shift_add_dp #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s),
    .step   (step_s),
    .finish (finish_s),
    .op     (bus.aluop),
    .a      (bus.a),
    .b      (bus.b),
    .result (result_s)
  );

  assign bus.stall  = stall_s;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_s;

endmodule

// Elaboration-time parameter legality checks for mul_sequencer.
module mul_sequencer_chk #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) ();
  if (XLEN != 32) begin : g_bad_xlen
    $error("mul_sequencer: XLEN must be 32");
  end
  if ((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2) && (BITS_PER_CYCLE != 4)) begin : g_bad_bpc
    $error("mul_sequencer: BITS_PER_CYCLE must be 1, 2 or 4");
  end
endmodule
